// File: rtl/mem_access_unit.sv
// Load/store unit sitting between the CPU request port and a single-port word memory.
// Each request runs IDLE -> ACCESS -> RESP and performs sub-word stores as a one-cycle read-modify-write.
module mem_access_unit #(
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_adr,
  input  logic [31:0] req_wd,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic        mem_write,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state;
  logic        we_q;
  logic        signed_q;
  logic        fault_q;
  logic [1:0]  size_q;
  logic [1:0]  lane_q;
  logic [31:0] wd_q;

  logic        req_fault;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_data;
  logic [31:0] store_word;

  // Size 11 always faults; misalignment only faults when alignment checking is enabled.
  always_comb begin
    req_fault = 1'b0;
    if (req_size == 2'b11)
      req_fault = 1'b1;
    else if (ALIGN_CHECK && req_size == 2'b01 && req_adr[0])
      req_fault = 1'b1;
    else if (ALIGN_CHECK && req_size == 2'b10 && req_adr[1:0] != 2'b00)
      req_fault = 1'b1;
  end

  always_comb begin
    byte_v    = mem_rd[{lane_q, 3'b000} +: 8];
    half_v    = mem_rd[{lane_q[1], 4'b0000} +: 16];
    load_data = mem_rd;
    case (size_q)
      2'b00:   load_data = {{24{signed_q & byte_v[7]}}, byte_v};
      2'b01:   load_data = {{16{signed_q & half_v[15]}}, half_v};
      default: load_data = mem_rd;
    endcase
  end

  // Sub-word stores merge the new lane into the word currently read back from memory.
  always_comb begin
    store_word = mem_rd;
    case (size_q)
      2'b00:   store_word[{lane_q, 3'b000} +: 8]    = wd_q[7:0];
      2'b01:   store_word[{lane_q[1], 4'b0000} +: 16] = wd_q[15:0];
      default: store_word = wd_q;
    endcase
  end

  assign mem_wd = (state == ACCESS && we_q && !fault_q) ? store_word : 32'd0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_fault <= 1'b0;
      mem_write  <= 1'b0;
      mem_adr    <= 32'd0;
      we_q       <= 1'b0;
      signed_q   <= 1'b0;
      fault_q    <= 1'b0;
      size_q     <= 2'b00;
      lane_q     <= 2'b00;
      wd_q       <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            state     <= ACCESS;
            req_ready <= 1'b0;
            we_q      <= req_we;
            signed_q  <= req_signed;
            size_q    <= req_size;
            lane_q    <= req_adr[1:0];
            wd_q      <= req_wd;
            fault_q   <= req_fault;
            mem_adr   <= {req_adr[31:2], 2'b00};
            mem_write <= req_we & ~req_fault;
          end
        end
        ACCESS: begin
          state      <= RESP;
          mem_write  <= 1'b0;
          mem_adr    <= 32'd0;
          resp_valid <= 1'b1;
          resp_fault <= fault_q;
          resp_rdata <= (we_q || fault_q) ? 32'd0 : load_data;
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_fault <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          mem_write  <= 1'b0;
          mem_adr    <= 32'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a word memory model, a response monitor
// popping expected {fault, rdata} entries, and directed load/store/fault/reset scenarios.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_adr = 32'd0;
  logic [31:0] req_wd = 32'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        mem_write;
  logic [31:0] mem_adr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [31:0] mem [0:63];
  logic        pre_we = 1'b0;
  logic [5:0]  pre_idx = 6'd0;
  logic [31:0] pre_data = 32'd0;

  logic [32:0] sb[$];
  int          total = 0;
  int          bad = 0;
  int          wr_count = 0;

  mem_access_unit #(.ALIGN_CHECK(1'b1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_adr(req_adr), .req_wd(req_wd),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_write(mem_write), .mem_adr(mem_adr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // Word memory: synchronous write, combinational read; preload port for test setup.
  always @(posedge clk) begin
    if (mem_write) mem[mem_adr[7:2]] <= mem_wd;
    else if (pre_we) mem[pre_idx] <= pre_data;
  end
  assign mem_rd = mem[mem_adr[7:2]];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h, want %h", tag, observed, expected);
    end
  endtask

  always @(negedge clk) if (mem_write) wr_count++;

  // Response monitor: every completed handshake consumes one scoreboard entry.
  always @(negedge clk) begin
    logic [32:0] e;
    if (reset && resp_valid && resp_ready) begin
      if (sb.size() == 0) checkOutput("unexpected_resp", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        checkOutput("rdata", resp_rdata, e[31:0]);
        checkOutput("fault", {31'd0, resp_fault}, {31'd0, e[32]});
      end
    end
  end

  task automatic preload(input logic [5:0] idx, input logic [31:0] data);
    @(negedge clk);
    pre_idx = idx; pre_data = data; pre_we = 1'b1;
    @(posedge clk); #1 pre_we = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    @(negedge clk);
    while (sb.size() != 0 && n < 20) begin @(negedge clk); n++; end
    checkOutput("drain", sb.size(), 32'd0);
  endtask

  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic sgn,
                               input logic [31:0] adr, input logic [31:0] wd,
                               input logic [31:0] exp_rdata, input logic exp_fault,
                               input int exp_writes);
    int n = 0;
    int wr0;
    sb.push_back({exp_fault, exp_rdata});
    wr0 = wr_count;
    @(negedge clk);
    req_we = we; req_size = size; req_signed = sgn; req_adr = adr; req_wd = wd;
    req_valid = 1'b1;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    checkOutput("req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    checkOutput("mem_adr", mem_adr, {adr[31:2], 2'b00});
    checkOutput("access_busy", {30'd0, resp_valid, req_ready}, 32'd0);
    @(negedge clk);
    checkOutput("latency", {31'd0, resp_valid}, 32'd1);
    waitDrain();
    checkOutput("writes", wr_count - wr0, exp_writes);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int wr0;
    repeat (3) @(negedge clk);
    checkOutput("rst_mem_write", {31'd0, mem_write}, 32'd0);
    checkOutput("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("rst_rdata", resp_rdata, 32'd0);
    checkOutput("rst_fault", {31'd0, resp_fault}, 32'd0);
    checkOutput("rst_mem_adr", mem_adr, 32'd0);
    checkOutput("rst_mem_wd", mem_wd, 32'd0);

    // Word store then load back
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0, 1);
    checkOutput("mem_word_store", mem[4], 32'hDEADBEEF);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0, 0);

    // Byte lane merge and extension
    preload(6'd4, 32'h11223344);
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h12, 32'h000000AA, 32'd0, 1'b0, 1);
    checkOutput("mem_byte_store", mem[4], 32'h11AA3344);
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h12, 32'd0, 32'hFFFFFFAA, 1'b0, 0);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h12, 32'd0, 32'h000000AA, 1'b0, 0);

    // Halfword loads and sub-word stores into the upper lanes
    preload(6'd8, 32'h8001FFFF);
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h22, 32'd0, 32'hFFFF8001, 1'b0, 0);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h20, 32'd0, 32'h0000FFFF, 1'b0, 0);
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h20, 32'h1234ABCD, 32'd0, 1'b0, 1);
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h23, 32'h0000005A, 32'd0, 1'b0, 1);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h20, 32'd0, 32'h5A01ABCD, 1'b0, 0);

    // Faulting requests never write
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h13, 32'hFFFFFFFF, 32'd0, 1'b1, 0);
    checkOutput("fault_mem_kept", mem[4], 32'h11AA3344);
    applyStimulus(1'b0, 2'b11, 1'b0, 32'h10, 32'd0, 32'd0, 1'b1, 0);
    applyStimulus(1'b1, 2'b11, 1'b0, 32'h10, 32'h01020304, 32'd0, 1'b1, 0);
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h21, 32'd0, 32'd0, 1'b1, 0);
    checkOutput("fault_mem_kept2", mem[4], 32'h11AA3344);

    // Backpressure: response held while a new request waits
    resp_ready = 1'b0;
    sb.push_back({1'b0, 32'h11AA3344});
    sb.push_back({1'b0, 32'd0});
    wr0 = wr_count;
    @(negedge clk);
    req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_adr = 32'h10; req_valid = 1'b1;
    @(posedge clk); #1;
    req_we = 1'b1; req_adr = 32'h30; req_wd = 32'h12345678;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("hold_valid", {31'd0, resp_valid}, 32'd1);
      checkOutput("hold_rdata", resp_rdata, 32'h11AA3344);
      checkOutput("hold_ready", {31'd0, req_ready}, 32'd0);
    end
    checkOutput("hold_no_write", wr_count - wr0, 32'd0);
    resp_ready = 1'b1;
    begin
      int n = 0;
      @(negedge clk);
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      checkOutput("hold_accept", {31'd0, req_ready}, 32'd1);
    end
    @(posedge clk); #1 req_valid = 1'b0;
    waitDrain();
    checkOutput("hold_store", mem[12], 32'h12345678);
    checkOutput("hold_writes", wr_count - wr0, 32'd1);

    // Reset in the middle of a store's ACCESS cycle
    preload(6'd13, 32'h55555555);
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b10; req_adr = 32'h34; req_wd = 32'h0; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    #1 checkOutput("mid_write_hi", {31'd0, mem_write}, 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("rst_mid_write", {31'd0, mem_write}, 32'd0);
    checkOutput("rst_mid_adr", mem_adr, 32'd0);
    checkOutput("rst_mid_wd", mem_wd, 32'd0);
    checkOutput("rst_mid_valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("rst_mid_rdata", resp_rdata, 32'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_mid_mem", mem[13], 32'h55555555);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("rst_mid_resp", {31'd0, resp_valid}, 32'd0);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h34, 32'd0, 32'h55555555, 1'b0, 0);

    checkOutput("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: ALIGN_CHECK, default 1, 1 = misaligned/illegal-size requests fault; 0 = low address bits ignored for word/half (forced aligned).
REQ-002 clk  in  1  single clock, all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-low; when 0 the block is in reset.
REQ-004 req_valid  in  1  CPU request present.
REQ-005 req_ready  out  1  unit can accept a request.
REQ-006 req_we  in  1  1 = store, 0 = load.
REQ-007 req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 req_signed  in  1  load sign-extension enable.
REQ-009 req_adr  in  32  byte address.
REQ-010 req_wd  in  32  store data, right-aligned.
REQ-011 resp_valid  out  1  response present.
REQ-012 resp_ready  in  1  CPU takes response.
REQ-013 resp_rdata  out  32  extended load data.
REQ-014 resp_fault  out  1  misaligned/illegal request.
REQ-015 mem_write  out  1  word write strobe to data memory.
REQ-016 mem_adr  out  32  word-aligned byte address to data memory.
REQ-017 mem_wd  out  32  write word to data memory.
REQ-018 mem_rd  in  32  combinational read word from data memory at mem_adr.

Function
REQ-019 FSM states IDLE, ACCESS, RESP; IDLE->ACCESS on accept; ACCESS->RESP always; RESP->IDLE when resp_ready=1, else hold.
REQ-020 req_ready = 1 only in IDLE; accept = req_valid & req_ready at rising edge; all req_* fields latched on accept.
REQ-021 req_valid outside IDLE has no effect; requester holds request until accepted.
REQ-022 Fault: ALIGN_CHECK=1 and (size=01 & adr[0]=1, or size=10 & adr[1:0]!=0); size=11 faults regardless of ALIGN_CHECK.
REQ-023 ACCESS: mem_adr = {adr[31:2],2'b00} for every request, faulting included.
REQ-024 ACCESS, non-faulting store: mem_write=1 for exactly this one cycle.
REQ-025 Word store: mem_wd = wd.
REQ-026 Sub-word store: mem_wd = mem_rd with the target lane replaced by low bits of wd; other lanes unchanged (read-modify-write in one cycle).
REQ-027 Lanes little-endian: byte lane k=adr[1:0] at bits [8k+7:8k]; half lane h=adr[1] at bits [16h+15:16h].
REQ-028 Faulting request or load: mem_write=0 throughout.
REQ-029 ACCESS, load: selected lane of mem_rd extracted, zero-extended, or sign-extended (req_signed=1) from bit 7/15, registered into resp_rdata.
REQ-030 Stores and faults: resp_rdata = 0.
REQ-031 RESP: resp_valid=1; resp_rdata and resp_fault stable until handshake.
REQ-032 Latency: accept at edge N; ACCESS cycle N..N+1; resp_valid high from edge N+1; back-to-back minimum 3 cycles per request when resp_ready=1.
REQ-033 Outside ACCESS: mem_write=0, mem_adr=0, mem_wd=0.
REQ-034 Outside RESP: resp_valid=0.

Reset
REQ-035 reset=0 asynchronously forces IDLE, req_ready=1 once released, resp_valid=0, resp_rdata=0, resp_fault=0, mem_write=0, mem_adr=0, mem_wd=0.
REQ-036 Reset mid-ACCESS drops the request; mem_write deasserts immediately; no partial write committed after reset assertion.
REQ-037 First accept possible at first rising edge with reset=1.

Verification
REQ-038 Bench memory model: word write on rising edge when mem_write=1, combinational read.
REQ-039 Word store adr 0x10, wd 0xDEADBEEF, then word load 0x10 -> mem_write one cycle, resp_rdata 0xDEADBEEF, resp_fault 0.
REQ-040 Mem[0x10]=0x11223344; byte store adr 0x12, wd 0xAA -> word becomes 0x11AA3344; signed byte load 0x12 -> 0xFFFFFFAA; unsigned -> 0x000000AA.
REQ-041 Mem[0x20]=0x8001FFFF; signed half load 0x22 -> 0xFFFF8001; unsigned half load 0x20 -> 0x0000FFFF.
REQ-042 Word store adr 0x13 (ALIGN_CHECK=1) -> resp_fault 1, resp_rdata 0, mem_write never 1, memory unchanged; size=11 also faults.
REQ-043 resp_ready held 0 for 5 cycles -> resp_valid and data held, req_ready 0, new req_valid ignored; after release next request accepted.
REQ-044 reset asserted during ACCESS of a store -> mem_write drops same cycle, target word unchanged, all outputs 0, FSM in IDLE.
